// File: rtl/axil_mem_responder.sv
// axil_mem_responder: AXI4-Lite single-beat responder in front of a word-organised RAM.
// Reads and writes are single-beat with byte strobes. Responses are OKAY, or SLVERR for
// addresses outside the RAM window. The two channels are independent, and each allows
// one outstanding transaction.
// Optional feature macro SIG_PORT_EN adds the SIG_DATA, SIG_VALID and SIM_DONE ports.
// These are driven by writes to 0xF0000004 (signature word) and 0xF0000000 (0xCAFECAFE ends the run).
module axil_mem_responder #(
    parameter int                    AXI_AWIDTH = 32,
    parameter int                    AXI_DWIDTH = 32,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [AXI_AWIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  AXI_ACLK,
    input  logic                  AXI_ARESETN,
`ifdef SIG_PORT_EN
    output logic [31:0]           SIG_DATA,
    output logic                  SIG_VALID,
    output logic                  SIM_DONE,
`endif
    input  logic [AXI_AWIDTH-1:0] AXI_AWADDR,
    input  logic                  AXI_AWVALID,
    output logic                  AXI_AWREADY,
    input  logic [AXI_DWIDTH-1:0] AXI_WDATA,
    input  logic [3:0]            AXI_WSTRB,
    input  logic                  AXI_WVALID,
    output logic                  AXI_WREADY,
    output logic [1:0]            AXI_BRESP,
    output logic                  AXI_BVALID,
    input  logic                  AXI_BREADY,
    input  logic [AXI_AWIDTH-1:0] AXI_ARADDR,
    input  logic                  AXI_ARVALID,
    output logic                  AXI_ARREADY,
    output logic [AXI_DWIDTH-1:0] AXI_RDATA,
    output logic [1:0]            AXI_RRESP,
    output logic                  AXI_RVALID,
    input  logic                  AXI_RREADY
);
    localparam int         IW     = $clog2(MEM_WORDS);
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    function automatic logic in_ram(input logic [AXI_AWIDTH-1:0] a);
        logic [AXI_AWIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ((off >> 2) < AXI_AWIDTH'(MEM_WORDS));
    endfunction

    function automatic logic [IW-1:0] ram_idx(input logic [AXI_AWIDTH-1:0] a);
        return IW'((a - BASE_ADDR) >> 2);
    endfunction

    logic [AXI_DWIDTH-1:0] mem_q [MEM_WORDS];

    logic [0:0]            w_state_q, w_state_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [AXI_AWIDTH-1:0] awaddr_q, awaddr_d;
    logic [AXI_DWIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  aw_hs, w_hs, b_hs, commit, c_in_ram, ram_we, sig_hit;
    logic [AXI_AWIDTH-1:0] c_addr;
    logic [AXI_DWIDTH-1:0] c_data;
    logic [3:0]            c_strb;

    logic [0:0]            r_state_q, r_state_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, ar_hs, r_hs;
    logic [AXI_DWIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    // Write channel: capture AW and W independently, commit once both are held, then hold B until accepted
    always_comb begin
        aw_hs     = AXI_AWVALID & awready_q;
        w_hs      = AXI_WVALID & wready_q;
        b_hs      = bvalid_q & AXI_BREADY;
        c_addr    = aw_held_q ? awaddr_q : AXI_AWADDR;
        c_data    = w_held_q ? wdata_q : AXI_WDATA;
        c_strb    = w_held_q ? wstrb_q : AXI_WSTRB;
        c_in_ram  = in_ram(c_addr);
        commit    = (w_state_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
        ram_we    = commit & c_in_ram & ~sig_hit;
        awaddr_d  = aw_hs ? AXI_AWADDR : awaddr_q;
        wdata_d   = w_hs ? AXI_WDATA : wdata_q;
        wstrb_d   = w_hs ? AXI_WSTRB : wstrb_q;
        aw_held_d = ~commit & (aw_held_q | aw_hs);
        w_held_d  = ~commit & (w_held_q | w_hs);
        awready_d = (w_state_q == W_RESP) ? b_hs : ~(commit | aw_held_q | aw_hs);
        wready_d  = (w_state_q == W_RESP) ? b_hs : ~(commit | w_held_q | w_hs);
        w_state_d = commit ? W_RESP : (b_hs ? W_IDLE : w_state_q);
        bvalid_d  = commit | (bvalid_q & ~AXI_BREADY);
        bresp_d   = commit ? ((sig_hit | c_in_ram) ? OKAY : SLVERR) : bresp_q;
    end

    // Write-channel state; a reset drops any half-captured request before it can commit
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // RAM write port with per-byte enables; contents are intentionally left unreset
    always_ff @(posedge AXI_ACLK) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (c_strb[i]) mem_q[ram_idx(c_addr)][8*i +: 8] <= c_data[8*i +: 8];
            end
        end
    end

    // Read channel: sample RAM on the AR handshake (old data wins over a same-edge write), hold R until accepted
    always_comb begin
        ar_hs     = AXI_ARVALID & arready_q;
        r_hs      = rvalid_q & AXI_RREADY;
        r_state_d = ar_hs ? R_DATA : (r_hs ? R_IDLE : r_state_q);
        arready_d = (r_state_q == R_DATA) ? r_hs : ~ar_hs;
        rvalid_d  = ar_hs | (rvalid_q & ~AXI_RREADY);
        rdata_d   = ar_hs ? (in_ram(AXI_ARADDR) ? mem_q[ram_idx(AXI_ARADDR)] : '0) : rdata_q;
        rresp_d   = ar_hs ? (in_ram(AXI_ARADDR) ? OKAY : SLVERR) : rresp_q;
    end

    // Read-channel state
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

`ifdef SIG_PORT_EN
    logic        is_sig, is_done;
    logic [31:0] sig_data_q, sig_data_d;
    logic        sig_valid_q, sig_valid_d, sim_done_q, sim_done_d;

    // Decode the two simulation-control words; they never touch RAM and always answer OKAY
    always_comb begin
        is_sig      = {c_addr[AXI_AWIDTH-1:2], 2'b00} == AXI_AWIDTH'(32'hF000_0004);
        is_done     = {c_addr[AXI_AWIDTH-1:2], 2'b00} == AXI_AWIDTH'(32'hF000_0000);
        sig_hit     = is_sig | is_done;
        sig_data_d  = (commit & is_sig) ? c_data : sig_data_q;
        sig_valid_d = commit & is_sig;
        sim_done_d  = sim_done_q | (commit & is_done & (c_data == 32'hCAFE_CAFE));
    end

    // Signature outputs; SIM_DONE is sticky until reset
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            sig_data_q  <= '0;
            sig_valid_q <= 1'b0;
            sim_done_q  <= 1'b0;
        end else begin
            sig_data_q  <= sig_data_d;
            sig_valid_q <= sig_valid_d;
            sim_done_q  <= sim_done_d;
        end
    end

    assign SIG_DATA  = sig_data_q;
    assign SIG_VALID = sig_valid_q;
    assign SIM_DONE  = sim_done_q;
`else
    assign sig_hit = 1'b0;
`endif

    assign AXI_AWREADY = awready_q;
    assign AXI_WREADY  = wready_q;
    assign AXI_BVALID  = bvalid_q;
    assign AXI_BRESP   = bresp_q;
    assign AXI_ARREADY = arready_q;
    assign AXI_RVALID  = rvalid_q;
    assign AXI_RDATA   = rdata_q;
    assign AXI_RRESP   = rresp_q;
endmodule

// File: tb/tb_axil_mem_responder.sv
// tb_axil_mem_responder: random and directed AXI4-Lite traffic checked against a word-array memory model.
module tb_axil_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
    logic [3:0]  WSTRB = '0;
    logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;
`ifdef SIG_PORT_EN
    logic [31:0] SIG_DATA;
    logic        SIG_VALID, SIM_DONE;
`endif

    always #5 clk = ~clk;

    axil_mem_responder dut (
        .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
`ifdef SIG_PORT_EN
        .SIG_DATA(SIG_DATA), .SIG_VALID(SIG_VALID), .SIM_DONE(SIM_DONE),
`endif
        .AXI_AWADDR(AWADDR), .AXI_AWVALID(AWVALID), .AXI_AWREADY(AWREADY),
        .AXI_WDATA(WDATA), .AXI_WSTRB(WSTRB), .AXI_WVALID(WVALID), .AXI_WREADY(WREADY),
        .AXI_BRESP(BRESP), .AXI_BVALID(BVALID), .AXI_BREADY(BREADY),
        .AXI_ARADDR(ARADDR), .AXI_ARVALID(ARVALID), .AXI_ARREADY(ARREADY),
        .AXI_RDATA(RDATA), .AXI_RRESP(RRESP), .AXI_RVALID(RVALID), .AXI_RREADY(RREADY)
    );

    int          n_cmp = 0, n_fail = 0;
    logic [31:0] mdl [0:1023];
    logic [1:0]  exp_bresp = '0, exp_rresp = '0;
    logic [31:0] exp_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit mdl_in(input logic [31:0] a);
        return (a >> 2) < 1024;
    endfunction

    function automatic logic [1:0] mdl_bresp(input logic [31:0] a);
`ifdef SIG_PORT_EN
        if ((a >> 2) == (32'hF000_0004 >> 2) || (a >> 2) == (32'hF000_0000 >> 2)) return 2'b00;
`endif
        return mdl_in(a) ? 2'b00 : 2'b10;
    endfunction

    // Response channels are compared against the model on every cycle their VALID is high
    always @(negedge clk) begin
        if (rst_n) begin
            if (BVALID) chk("bresp", {30'd0, BRESP}, {30'd0, exp_bresp});
            if (RVALID) begin
                chk("rdata", RDATA, exp_rdata);
                chk("rresp", {30'd0, RRESP}, {30'd0, exp_rresp});
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, {31'd0, AWREADY}, 0);
        chk({tag, "_wready"}, {31'd0, WREADY}, 0);
        chk({tag, "_arready"}, {31'd0, ARREADY}, 0);
        chk({tag, "_bvalid"}, {31'd0, BVALID}, 0);
        chk({tag, "_rvalid"}, {31'd0, RVALID}, 0);
        chk({tag, "_bresp"}, {30'd0, BRESP}, 0);
        chk({tag, "_rresp"}, {30'd0, RRESP}, 0);
        chk({tag, "_rdata"}, RDATA, 0);
    endtask

    task automatic do_write(input logic [31:0] a, d, input logic [3:0] s, input int da, dw, db,
                            output logic [1:0] got);
        bit ad = 0, wd = 0, ha, hw;
        int cyc = 0;
        exp_bresp = mdl_bresp(a);
        AWADDR = a; WDATA = d; WSTRB = s;
        while (!(ad && wd)) begin
            AWVALID = !ad && cyc >= da;
            WVALID = !wd && cyc >= dw;
            @(negedge clk);
            chk("bvalid_early", {31'd0, BVALID}, 0);
            chk("awready_idle", {31'd0, AWREADY}, {31'd0, !ad});
            chk("wready_idle", {31'd0, WREADY}, {31'd0, !wd});
            ha = AWVALID && AWREADY;
            hw = WVALID && WREADY;
            @(posedge clk); #1;
            ad = ad | ha;
            wd = wd | hw;
            cyc++;
            if (cyc > 40) begin
                n_cmp++; n_fail++;
                $display("FAIL w_timeout: aw=%0d w=%0d expected both handshakes", ad, wd);
                break;
            end
        end
        AWVALID = 0; WVALID = 0;
        chk("bvalid_latency", {31'd0, BVALID}, 1);
        got = BRESP;
`ifdef SIG_PORT_EN
        chk("sig_valid_pulse", {31'd0, SIG_VALID}, {31'd0, (a >> 2) == (32'hF000_0004 >> 2)});
        if ((a >> 2) == (32'hF000_0004 >> 2)) chk("sig_data", SIG_DATA, d);
`endif
        repeat (db) begin
            @(negedge clk);
            chk("b_hold", {31'd0, BVALID}, 1);
            chk("aw_stall", {31'd0, AWREADY}, 0);
            chk("w_stall", {31'd0, WREADY}, 0);
            @(posedge clk); #1;
        end
        BREADY = 1;
        @(posedge clk); #1;
        BREADY = 0;
        chk("b_clear", {31'd0, BVALID}, 0);
        chk("awready_back", {31'd0, AWREADY}, 1);
        chk("wready_back", {31'd0, WREADY}, 1);
`ifdef SIG_PORT_EN
        chk("sig_valid_low", {31'd0, SIG_VALID}, 0);
`endif
        if (mdl_in(a))
            for (int i = 0; i < 4; i++) if (s[i]) mdl[a[11:2]][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic do_read(input logic [31:0] a, input int dar, dr,
                           output logic [31:0] got_d, output logic [1:0] got_r);
        bit done = 0, h;
        int cyc = 0;
        exp_rdata = mdl_in(a) ? mdl[a[11:2]] : 32'h0;
        exp_rresp = mdl_in(a) ? 2'b00 : 2'b10;
        ARADDR = a;
        while (!done) begin
            ARVALID = cyc >= dar;
            @(negedge clk);
            chk("rvalid_early", {31'd0, RVALID}, 0);
            chk("arready_idle", {31'd0, ARREADY}, 1);
            h = ARVALID && ARREADY;
            @(posedge clk); #1;
            done = h;
            cyc++;
            if (cyc > 40) begin
                n_cmp++; n_fail++;
                $display("FAIL r_timeout: no AR handshake, expected one");
                break;
            end
        end
        ARVALID = 0;
        chk("rvalid_latency", {31'd0, RVALID}, 1);
        chk("arready_drop", {31'd0, ARREADY}, 0);
        got_d = RDATA;
        got_r = RRESP;
        repeat (dr) begin
            @(negedge clk);
            chk("r_hold", {31'd0, RVALID}, 1);
            chk("ar_stall", {31'd0, ARREADY}, 0);
            @(posedge clk); #1;
        end
        RREADY = 1;
        @(posedge clk); #1;
        RREADY = 0;
        chk("r_clear", {31'd0, RVALID}, 0);
        chk("arready_back", {31'd0, ARREADY}, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rd, old, a;
        // reset state and release timing
        #2 chk_reset_outputs("reset");
        @(negedge clk); rst_n = 1;
        #1 chk("ready_before_edge", {31'd0, AWREADY}, 0);
        @(posedge clk); #1;
        chk("awready_after_rst", {31'd0, AWREADY}, 1);
        chk("wready_after_rst", {31'd0, WREADY}, 1);
        chk("arready_after_rst", {31'd0, ARREADY}, 1);
        // give every test word a known value
        for (int w = 0; w < 16; w++)
            do_write(w * 4, $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), br);
        // full write, W two cycles after AW, then readback
        do_write(32'h10, 32'h1234_5678, 4'hF, 0, 2, 0, br);
        chk("t2_bresp", {30'd0, br}, 0);
        do_read(32'h10, 0, 0, rd, rr);
        chk("t2_rdata", rd, 32'h1234_5678);
        // single-byte strobe merge
        do_write(32'h10, 32'hAABB_CCDD, 4'b0100, 1, 0, 0, br);
        do_read(32'h10, 0, 1, rd, rr);
        chk("t3_rdata", rd, 32'h12BB_5678);
        // held write response stalls both write channels
        do_write(32'h14, 32'h0BAD_F00D, 4'b0011, 0, 0, 5, br);
        // out-of-range write and read, plus word 0 must not alias
        do_write(32'h1000, 32'h55AA_55AA, 4'hF, 0, 0, 0, br);
        chk("t5_bresp", {30'd0, br}, 2);
        do_read(32'h1000, 0, 0, rd, rr);
        chk("t5_rdata", rd, 0);
        chk("t5_rresp", {30'd0, rr}, 2);
        do_read(32'h0, 0, 0, rd, rr);
        // AW, W and AR on the same edge to the same word: read returns the pre-write value
        old = mdl[3];
        exp_rdata = old; exp_rresp = 2'b00; exp_bresp = 2'b00;
        AWADDR = 32'hC; WDATA = ~old; WSTRB = 4'hF; ARADDR = 32'hC;
        AWVALID = 1; WVALID = 1; ARVALID = 1;
        @(posedge clk); #1;
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        chk("same_edge_bvalid", {31'd0, BVALID}, 1);
        chk("same_edge_rvalid", {31'd0, RVALID}, 1);
        chk("same_edge_rdata", RDATA, old);
        BREADY = 1; RREADY = 1;
        @(posedge clk); #1;
        BREADY = 0; RREADY = 0;
        mdl[3] = ~old;
        do_read(32'hC, 0, 0, rd, rr);
        chk("same_edge_after", rd, ~old);
        // reset with an AW captured and a read response pending
        AWADDR = 32'h10; AWVALID = 1;
        @(posedge clk); #1;
        AWVALID = 0;
        chk("aw_captured", {31'd0, AWREADY}, 0);
        exp_rdata = mdl[5]; exp_rresp = 2'b00;
        ARADDR = 32'h14; ARVALID = 1;
        @(posedge clk); #1;
        ARVALID = 0;
        chk("pending_rvalid", {31'd0, RVALID}, 1);
        #2 rst_n = 0;
        #1 chk_reset_outputs("midreset");
        @(negedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        chk("awready_rerelease", {31'd0, AWREADY}, 1);
        WDATA = 32'hFFFF_FFFF; WSTRB = 4'hF; WVALID = 1;
        @(posedge clk); #1;
        WVALID = 0;
        repeat (3) @(posedge clk);
        #1 chk("no_stale_commit", {31'd0, BVALID}, 0);
        AWADDR = 32'h18; AWVALID = 1;
        exp_bresp = 2'b00;
        @(posedge clk); #1;
        AWVALID = 0;
        chk("late_aw_commit", {31'd0, BVALID}, 1);
        BREADY = 1;
        @(posedge clk); #1;
        BREADY = 0;
        mdl[6] = 32'hFFFF_FFFF;
        do_read(32'h10, 0, 0, rd, rr);
        do_read(32'h18, 0, 0, rd, rr);
        // random traffic
        for (int k = 0; k < 200; k++) begin
            logic [3:0] w4;
            logic [1:0] lo;
            w4 = 4'($urandom_range(0, 15));
            lo = 2'($urandom);
            a = ($urandom_range(0, 9) == 0) ? 32'h1000 + ($urandom_range(0, 4095) << 2) : {26'd0, w4, lo};
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br);
            else
                do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), rd, rr);
        end
`ifdef SIG_PORT_EN
        chk("sim_done_init", {31'd0, SIM_DONE}, 0);
        do_write(32'hF000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, br);
        chk("sig_data_held", SIG_DATA, 32'hDEAD_BEEF);
        do_write(32'hF000_0000, 32'h1234_0000, 4'hF, 0, 0, 0, br);
        chk("sim_done_other", {31'd0, SIM_DONE}, 0);
        do_write(32'hF000_0000, 32'hCAFE_CAFE, 4'hF, 0, 0, 0, br);
        chk("sim_done_set", {31'd0, SIM_DONE}, 1);
        do_write(32'hF000_0000, 32'h0, 4'hF, 0, 0, 0, br);
        chk("sim_done_sticky", {31'd0, SIM_DONE}, 1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
